micro_sequencer_axi_writer: RTL and testbench

- Single-outstanding AXI4-Lite write master sitting directly downstream of the micro sequencer's register-write port (wdata/waddr/wstrb/write strobe).
- Converts each one-cycle write request into one AXI write transaction toward the PL peripheral interconnect.
- Returns busy, failed and timeout status to the sequencer so it can stall or flag errors.
- Write-only: the AXI read channels are tied off in the block design, not in this module.

---
 rtl/micro_sequencer_axi_writer_pkg.sv | 23 ++
 rtl/micro_sequencer_axi_writer.sv | 152 +++++++++++++++
 tb/tb_micro_sequencer_axi_writer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_axi_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_axi_writer_pkg
//  Description : Shared state encoding and AXI constants for the sequencer
//                AXI4-Lite write master.
//  Revision    : 1.0 - initial release
// ============================================================================
package micro_sequencer_axi_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_DATA = 2'd1,
        ST_RESP      = 2'd2
    } state_t;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [2:0] c_AWPROT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_axi_writer.sv
`default_nettype none
// ============================================================================
//  Module      : micro_sequencer_axi_writer
//  Description : Single-outstanding AXI4-Lite write master fed by the micro
//                sequencer register-write port, with busy/error/timeout status.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer_axi_writer
    import micro_sequencer_axi_writer_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] axi_wdata,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] axi_waddr,
    input  logic [3:0]                    axi_wstrb,
    input  logic                          axi_write,
    output logic                          axi_write_busy,
    output logic                          axi_write_failed,
    output logic                          axi_write_timeout,
    output logic                          write_dropped,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                        r_state;
    state_t                        w_next_state;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [3:0]                    r_wstrb;
    logic                          r_failed;
    logic                          r_timeout;
    logic                          r_dropped;
    logic [CNT_W-1:0]              r_count;

    logic w_accept;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_b_hs;
    logic w_resp_err;

    // A channel counts as finished once its valid is low or its handshake
    // completes this cycle, so same-edge completion of both is covered.
    assign w_accept   = (r_state == ST_IDLE) && axi_write;
    assign w_aw_fin   = !r_awvalid || M_AXI_AWREADY;
    assign w_w_fin    = !r_wvalid  || M_AXI_WREADY;
    assign w_b_hs     = M_AXI_BVALID && r_bready;
    assign w_resp_err = (M_AXI_BRESP == c_RESP_SLVERR) || (M_AXI_BRESP == c_RESP_DECERR);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (axi_write)            w_next_state = ST_ADDR_DATA;
            ST_ADDR_DATA: if (w_aw_fin && w_w_fin)  w_next_state = ST_RESP;
            ST_RESP:      if (w_b_hs)               w_next_state = ST_IDLE;
            default:                                w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_failed  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_awaddr  <= axi_waddr;
                r_wdata   <= axi_wdata;
                r_wstrb   <= axi_wstrb;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_failed  <= 1'b0;
            end
            if (r_state == ST_ADDR_DATA) begin
                if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
                if (r_wvalid  && M_AXI_WREADY)  r_wvalid  <= 1'b0;
                if (w_aw_fin && w_w_fin)        r_bready  <= 1'b1;
            end
            if ((r_state == ST_RESP) && w_b_hs) begin
                r_bready <= 1'b0;
                r_failed <= w_resp_err;
            end
        end
    end

    // Timeout only flags a slow slave; the transaction keeps waiting for B.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (r_count != c_CNT_MAX)  r_count   <= r_count + CNT_W'(1);
            if (r_count == c_CNT_TRIP) r_timeout <= 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_dropped <= 1'b0;
        end else if (axi_write && (r_state != ST_IDLE)) begin
            r_dropped <= 1'b1;
        end
    end

    assign axi_write_busy    = (r_state != ST_IDLE) || axi_write;
    assign axi_write_failed  = r_failed;
    assign axi_write_timeout = r_timeout;
    assign write_dropped     = r_dropped;
    assign M_AXI_AWADDR      = r_awaddr;
    assign M_AXI_AWPROT      = c_AWPROT;
    assign M_AXI_AWVALID     = r_awvalid;
    assign M_AXI_WDATA       = r_wdata;
    assign M_AXI_WSTRB       = r_wstrb;
    assign M_AXI_WVALID      = r_wvalid;
    assign M_AXI_BREADY      = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer_axi_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_micro_sequencer_axi_writer
//  Description : Scoreboard bench for the sequencer AXI4-Lite write master
//                with a latency-programmable AXI slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer_axi_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] axi_wdata;
    logic [31:0] axi_waddr;
    logic [3:0]  axi_wstrb;
    logic        axi_write;
    logic        busy, failed, timeout, dropped;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [1:0]  exp_b[$];

    int          aw_lat, w_lat, b_lat;
    logic [1:0]  bresp_cfg;
    int          aw_cnt, w_cnt, b_cnt;
    logic        aw_done, w_done, b_pend;

    always #5 clk = ~clk;

    micro_sequencer_axi_writer #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .M_AXI_ACLK        (clk),
        .M_AXI_ARESETN     (rst_n),
        .axi_wdata         (axi_wdata),
        .axi_waddr         (axi_waddr),
        .axi_wstrb         (axi_wstrb),
        .axi_write         (axi_write),
        .axi_write_busy    (busy),
        .axi_write_failed  (failed),
        .axi_write_timeout (timeout),
        .write_dropped     (dropped),
        .M_AXI_AWADDR      (awaddr),
        .M_AXI_AWPROT      (awprot),
        .M_AXI_AWVALID     (awvalid),
        .M_AXI_AWREADY     (awready),
        .M_AXI_WDATA       (wdata),
        .M_AXI_WSTRB       (wstrb),
        .M_AXI_WVALID      (wvalid),
        .M_AXI_WREADY      (wready),
        .M_AXI_BRESP       (bresp),
        .M_AXI_BVALID      (bvalid),
        .M_AXI_BREADY      (bready)
    );

    // Slave model: each ready rises after its valid has waited *_lat cycles;
    // B is offered b_lat cycles after both AW and W have completed.
    assign awready = awvalid && (aw_cnt >= aw_lat);
    assign wready  = wvalid  && (w_cnt  >= w_lat);
    assign bvalid  = b_pend  && (b_cnt  >= b_lat);
    assign bresp   = bvalid ? bresp_cfg : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
            if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                b_pend  <= 1'b1;
                b_cnt   <= 0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                aw_done <= aw_done || (awvalid && awready);
                w_done  <= w_done  || (wvalid && wready);
                if (b_pend) begin
                    if (bvalid && bready) b_pend <= 1'b0;
                    else                  b_cnt  <= b_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    // Scoreboard monitors: compare channel payloads at each handshake.
    always @(negedge clk) begin
        if (rst_n && awvalid && awready) begin
            if (exp_aw.size() == 0) fail_now("aw_unexpected");
            else check("aw_addr", awaddr, exp_aw.pop_front());
            check("aw_prot", awprot, 3'b000);
        end
        if (rst_n && wvalid && wready) begin
            if (exp_w.size() == 0) fail_now("w_unexpected");
            else check("w_data_strb", {wstrb, wdata}, exp_w.pop_front());
        end
    end

    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    e = exp_b.pop_front();
                    @(posedge clk); #1;
                    check("b_failed", failed, e[1]);
                    check("b_timeout", timeout, e[0]);
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic exp_fail, input logic exp_to);
        @(negedge clk);
        axi_waddr = a; axi_wdata = d; axi_wstrb = s; axi_write = 1'b1;
        exp_aw.push_back(a);
        exp_w.push_back({s, d});
        exp_b.push_back({exp_fail, exp_to});
        #1 check("busy_req_cycle", busy, 1'b1);
        @(posedge clk); #1;
        axi_write = 1'b0;
        check("accept_failed_clr", failed, 1'b0);
        check("accept_timeout_clr", timeout, 1'b0);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) fail_now("wait_idle_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; axi_write = 1'b0; axi_waddr = '0; axi_wdata = '0; axi_wstrb = '0;
        aw_lat = 0; w_lat = 0; b_lat = 0; bresp_cfg = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_regs", {awaddr, wdata, wstrb}, 68'h0);
        check("rst_flags", {failed, timeout, dropped, busy}, 4'b0000);
        @(negedge clk) rst_n = 1'b1;

        // Single write, always-ready slave
        do_write(32'h4000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        check("t1_valids_up", {awvalid, wvalid, bready, busy}, 4'b1101);
        check("t1_awaddr", awaddr, 32'h4000_1000);
        @(posedge clk); #1;
        check("t1_resp_state", {awvalid, wvalid, bready, busy}, 4'b0011);
        @(posedge clk); #1;
        check("t1_done", {bready, busy}, 2'b00);

        // Skewed ready: AW delayed 5 cycles
        aw_lat = 5;
        do_write(32'h4000_2000, 32'h1234_5678, 4'h3, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t2_w_dropped_aw_held", {awvalid, wvalid, bready}, 3'b100);
        repeat (4) @(posedge clk);
        #1;
        check("t2_aw_still_held", {awvalid, bready}, 2'b10);
        check("t2_addr_stable", awaddr, 32'h4000_2000);
        @(posedge clk); #1;
        check("t2_resp_after_aw", {awvalid, bready}, 2'b01);
        wait_idle(10);
        aw_lat = 0;

        // Error responses then OKAY
        bresp_cfg = 2'b10;
        do_write(32'h4000_3000, 32'h0000_0001, 4'h1, 1'b1, 1'b0);
        wait_idle(10);
        check("t3_slverr_failed", failed, 1'b1);
        bresp_cfg = 2'b11;
        do_write(32'h4000_3004, 32'h0000_0002, 4'h2, 1'b1, 1'b0);
        wait_idle(10);
        bresp_cfg = 2'b00;
        do_write(32'h4000_3008, 32'h0000_0003, 4'h4, 1'b0, 1'b0);
        wait_idle(10);
        check("t3_okay_failed", failed, 1'b0);

        // Timeout at 16 cycles with a 40-cycle B latency
        b_lat = 40;
        do_write(32'h4000_4000, 32'hA5A5_5A5A, 4'hF, 1'b0, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        check("t4_no_timeout_yet", {timeout, busy}, 2'b01);
        @(posedge clk); #1;
        check("t4_timeout_set", {timeout, busy}, 2'b11);
        repeat (10) @(posedge clk);
        #1;
        check("t4_still_busy", busy, 1'b1);
        wait_idle(60);
        check("t4_timeout_sticky", timeout, 1'b1);
        b_lat = 0;
        do_write(32'h4000_4004, 32'h0000_0004, 4'h8, 1'b0, 1'b0);
        wait_idle(10);

        // Request while busy is dropped
        do_write(32'h4000_5000, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
        axi_waddr = 32'h4000_9999; axi_wdata = 32'h1111_1111; axi_write = 1'b1;
        #1 check("t5_busy", busy, 1'b1);
        @(posedge clk); #1;
        axi_write = 1'b0;
        check("t5_awaddr_kept", awaddr, 32'h4000_5000);
        check("t5_dropped", dropped, 1'b1);
        wait_idle(10);
        do_write(32'h4000_5004, 32'h0000_0005, 4'hF, 1'b0, 1'b0);
        wait_idle(10);
        check("t5_dropped_sticky", dropped, 1'b1);

        // Asynchronous reset in RESP
        b_lat = 10;
        do_write(32'h4000_6000, 32'h6666_6666, 4'hF, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t6_in_resp", bready, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_valids", {awvalid, wvalid, bready, busy}, 4'b0000);
        check("t6_async_regs", {awaddr, wdata, wstrb}, 68'h0);
        check("t6_async_flags", {failed, timeout, dropped}, 3'b000);
        exp_b.delete();
        b_lat = 0;
        @(negedge clk) rst_n = 1'b1;
        do_write(32'h4000_7000, 32'h7777_7777, 4'hC, 1'b0, 1'b0);
        wait_idle(10);
        check("t6_post_reset_idle", {busy, failed, timeout}, 3'b000);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", exp_aw.size() + exp_w.size() + exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
